// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the debug unit, the pipeline stage registers and pipeline_sequencer.
// The master modport is the debug/pipeline side; the slave modport is the sequencer.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             step_req;
    logic             stop_req;
    logic             id_halt;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             clk_en;
    logic             stall;
    logic             flush;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, step_req, stop_req, id_halt,
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
        input  clk_en, stall, flush, busy, halted, cycle_count
    );

    modport slave (
        input  start, step_req, stop_req, id_halt,
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
        output clk_en, stall, flush, busy, halted, cycle_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard controller for the IF/ID register: debug run/step/pause,
// drain-then-freeze after HALT reaches ID, and load-use stall detection.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input logic                 clk,
    input logic                 reset,
    pipeline_sequencer_if.slave bus
);
    localparam int              DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        STEP,
        DRAIN,
        HALTED
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [DW-1:0]    r_drainCount;
    logic [DW-1:0]    w_nextDrain;
    logic             r_clkEn;
    logic             r_flush;
    logic             r_busy;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycleCount;
    logic             w_hazard;
    logic             w_stall;
    logic             w_haltAccept;
    logic             w_nextActive;

    // Register 0 is hardwired, so a load targeting it never creates a real dependency.
    assign w_hazard = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                      ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));
    assign w_stall      = r_clkEn && w_hazard;
    assign w_haltAccept = bus.id_halt && !w_stall;

    always_comb begin
        w_nextState = r_state;
        w_nextDrain = r_drainCount;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = RUN;
                end else if (bus.step_req) begin
                    w_nextState = STEP;
                end
            end
            FLUSH: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (w_haltAccept) begin
                    w_nextState = DRAIN;
                    w_nextDrain = DRAIN_LOAD;
                end else if (bus.stop_req) begin
                    w_nextState = IDLE;
                end
            end
            STEP: begin
                if (w_haltAccept) begin
                    w_nextState = DRAIN;
                    w_nextDrain = DRAIN_LOAD;
                end else begin
                    w_nextState = IDLE;
                end
            end
            DRAIN: begin
                w_nextDrain = r_drainCount - DRAIN_LAST;
                if (r_drainCount == DRAIN_LAST) begin
                    w_nextState = HALTED;
                end
            end
            HALTED: begin
                if (bus.start) begin
                    w_nextState = FLUSH;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_nextActive = (w_nextState == FLUSH) || (w_nextState == RUN) ||
                          (w_nextState == STEP)  || (w_nextState == DRAIN);

    // Moore outputs are decoded from the next state so they are glitch-free registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_drainCount <= '0;
            r_cycleCount <= '0;
            r_clkEn      <= 1'b0;
            r_flush      <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_drainCount <= w_nextDrain;
            r_clkEn      <= w_nextActive;
            r_busy       <= w_nextActive;
            r_flush      <= (w_nextState == FLUSH);
            r_halted     <= (w_nextState == HALTED);
            if ((r_state == HALTED) && bus.start) begin
                r_cycleCount <= '0;
            end else if (r_clkEn && (r_cycleCount != CNT_MAX)) begin
                r_cycleCount <= r_cycleCount + 1'b1;
            end
        end
    end

    assign bus.clk_en      = r_clkEn;
    assign bus.stall       = w_stall;
    assign bus.flush       = r_flush;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;
    assign bus.cycle_count = r_cycleCount;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed testbench for pipeline_sequencer: reset, single-step, load-use stall,
// HALT drain (plain and stalled), restart from HALTED, and counter saturation.
module tb_pipeline_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CNT_W(32)) bus ();
    pipeline_sequencer_if #(.CNT_W(3))  smallBus ();

    pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_W(3)) dutSmall (
        .clk   (clk),
        .reset (reset),
        .bus   (smallBus.slave)
    );

    // {clk_en, flush, busy, halted, stall}
    logic [4:0] flags;
    assign flags = {bus.clk_en, bus.flush, bus.busy, bus.halted, bus.stall};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.start = 0; bus.step_req = 0; bus.stop_req = 0; bus.id_halt = 0;
        bus.id_ex_mem_read = 0; bus.id_ex_rt = 0; bus.if_id_rs = 0; bus.if_id_rt = 0;
        smallBus.start = 0; smallBus.step_req = 0; smallBus.stop_req = 0; smallBus.id_halt = 0;
        smallBus.id_ex_mem_read = 0; smallBus.id_ex_rt = 0; smallBus.if_id_rs = 0; smallBus.if_id_rt = 0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 1;
        bus.start = 1;
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 5'd5; bus.if_id_rs = 5'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (flags !== 5'b00000) begin
                errors++;
                $display("[TB] FAIL reset_flags[%0d]: got %b expected %b", i, flags, 5'b00000);
            end
            checks++;
            if (bus.cycle_count !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_count[%0d]: got %0d expected 0", i, bus.cycle_count);
            end
        end
        reset = 0;
        tick();
        checks++;
        if (flags !== 5'b10101) begin
            errors++;
            $display("[TB] FAIL reset_release_run: got %b expected %b", flags, 5'b10101);
        end
    endtask

    task automatic test_step();
        doReset();
        for (int k = 0; k < 3; k++) begin
            bus.step_req = 1;
            tick();
            bus.step_req = 0;
            checks++;
            if (flags !== 5'b10100) begin
                errors++;
                $display("[TB] FAIL step_on[%0d]: got %b expected %b", k, flags, 5'b10100);
            end
            for (int g = 0; g < 2; g++) begin
                tick();
                checks++;
                if (flags !== 5'b00000) begin
                    errors++;
                    $display("[TB] FAIL step_gap[%0d.%0d]: got %b expected %b", k, g, flags, 5'b00000);
                end
            end
        end
        checks++;
        if (bus.cycle_count !== 32'd3) begin
            errors++;
            $display("[TB] FAIL step_count: got %0d expected 3", bus.cycle_count);
        end
    endtask

    task automatic test_load_use();
        doReset();
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 5'd5; bus.if_id_rs = 5'd5; bus.if_id_rt = 5'd9;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_rs_match: got %b expected 1", bus.stall);
        end
        bus.if_id_rs = 5'd3; bus.if_id_rt = 5'd5;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_rt_match: got %b expected 1", bus.stall);
        end
        bus.id_ex_rt = 5'd0; bus.if_id_rs = 5'd0; bus.if_id_rt = 5'd0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_reg0: got %b expected 0", bus.stall);
        end
        bus.id_ex_rt = 5'd5; bus.if_id_rs = 5'd6; bus.if_id_rt = 5'd7;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_nomatch: got %b expected 0", bus.stall);
        end
        bus.id_ex_mem_read = 0; bus.if_id_rs = 5'd5;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_noload: got %b expected 0", bus.stall);
        end
        bus.stop_req = 1;
        tick();
        bus.stop_req = 0;
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 5'd5; bus.if_id_rs = 5'd5;
        #1;
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL stall_idle: got %b expected %b", flags, 5'b00000);
        end
    endtask

    task automatic test_halt_drain();
        doReset();
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.id_halt = 1;
        bus.stop_req = 1;
        tick();
        bus.id_halt = 0;
        checks++;
        if (flags !== 5'b10100 || bus.cycle_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL drain_enter: flags %b count %0d expected %b count 1", flags, bus.cycle_count, 5'b10100);
        end
        bus.step_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (flags !== 5'b10100) begin
                errors++;
                $display("[TB] FAIL drain_cycle[%0d]: got %b expected %b", i + 2, flags, 5'b10100);
            end
        end
        bus.step_req = 0; bus.stop_req = 0;
        tick();
        checks++;
        if (flags !== 5'b00010 || bus.cycle_count !== 32'd5) begin
            errors++;
            $display("[TB] FAIL drain_halted: flags %b count %0d expected %b count 5", flags, bus.cycle_count, 5'b00010);
        end
        bus.step_req = 1; bus.stop_req = 1;
        tick();
        tick();
        bus.step_req = 0; bus.stop_req = 0;
        checks++;
        if (flags !== 5'b00010 || bus.cycle_count !== 32'd5) begin
            errors++;
            $display("[TB] FAIL halted_ignores_step: flags %b count %0d expected %b count 5", flags, bus.cycle_count, 5'b00010);
        end
    endtask

    task automatic test_halt_stall();
        doReset();
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.id_halt = 1;
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 5'd5; bus.if_id_rs = 5'd5;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL halt_stall_active: got %b expected 1", bus.stall);
        end
        tick();
        bus.id_ex_mem_read = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (flags !== 5'b10100) begin
                errors++;
                $display("[TB] FAIL halt_stall_drain[%0d]: got %b expected %b", i + 2, flags, 5'b10100);
            end
        end
        tick();
        bus.id_halt = 0;
        checks++;
        if (flags !== 5'b00010 || bus.cycle_count !== 32'd6) begin
            errors++;
            $display("[TB] FAIL halt_stall_halted: flags %b count %0d expected %b count 6", flags, bus.cycle_count, 5'b00010);
        end
    endtask

    task automatic test_restart();
        bus.start = 1;
        tick();
        bus.start = 0;
        checks++;
        if (flags !== 5'b11100 || bus.cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL restart_flush: flags %b count %0d expected %b count 0", flags, bus.cycle_count, 5'b11100);
        end
        tick();
        checks++;
        if (flags !== 5'b10100 || bus.cycle_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL restart_run: flags %b count %0d expected %b count 1", flags, bus.cycle_count, 5'b10100);
        end
        bus.id_halt = 1;
        tick();
        bus.id_halt = 0;
        tick();
        bus.id_ex_mem_read = 1; bus.id_ex_rt = 5'd7; bus.if_id_rt = 5'd7;
        #1;
        checks++;
        if (flags !== 5'b10101 || bus.cycle_count !== 32'd3) begin
            errors++;
            $display("[TB] FAIL drain2_stall: flags %b count %0d expected %b count 3", flags, bus.cycle_count, 5'b10101);
        end
        reset = 1;
        tick();
        checks++;
        if (flags !== 5'b00000 || bus.cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_drain: flags %b count %0d expected %b count 0", flags, bus.cycle_count, 5'b00000);
        end
        reset = 0;
        clearInputs();
        tick();
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL after_reset_idle: got %b expected %b", flags, 5'b00000);
        end
    endtask

    task automatic test_saturate();
        doReset();
        smallBus.start = 1;
        tick();
        smallBus.start = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        checks++;
        if (smallBus.cycle_count !== 3'd7 || smallBus.clk_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL count_saturate: count %0d clk_en %b expected count 7 clk_en 1", smallBus.cycle_count, smallBus.clk_en);
        end
        smallBus.stop_req = 1;
        tick();
        smallBus.stop_req = 0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_load_use();
        test_halt_drain();
        test_halt_stall();
        test_restart();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Run-control and hazard controller for the IF/ID pipeline register and downstream stages.
- Drives the `clk_en`, `stall` and `flush` inputs of the IF/ID stage register.
- Sequences debug run/step/pause, drains the pipeline after a HALT instruction reaches ID, and detects load-use hazards.
- Sits between the debug unit (`start`/`step`/`stop` requests) and the pipeline stage registers.

Parameters:
- DRAIN_CYCLES, 4, number of enabled cycles after HALT is latched in ID before freezing (lets EX/MEM/WB retire).
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  debug request: run continuously.
- step_req  input  1  debug request: advance exactly one cycle.
- stop_req  input  1  debug request: pause (no drain).
- id_halt  input  1  instruction currently in IF/ID decodes as HALT.
- id_ex_mem_read  input  1  instruction in ID/EX is a load.
- id_ex_rt  input  5  destination register of the load in ID/EX.
- if_id_rs  input  5  rs field of the instruction in IF/ID.
- if_id_rt  input  5  rt field of the instruction in IF/ID.
- clk_en  output  1  pipeline advance enable (all stage registers and PC).
- stall  output  1  hold PC and IF/ID, bubble into ID/EX.
- flush  output  1  clear IF/ID.
- busy  output  1  high in FLUSH, RUN, STEP, DRAIN.
- halted  output  1  high in HALTED.
- cycle_count  output  CNT_W  number of cycles with clk_en=1.

Behaviour:
- States: IDLE, FLUSH, RUN, STEP, DRAIN, HALTED. Single registered state; outputs are Moore-decoded from state, except `stall`.
- Reset (synchronous, `clk` edge with `reset`=1):
  - state IDLE, drain counter 0, cycle_count 0.
  - clk_en, flush, busy and halted all 0. stall is 0 because it is gated by clk_en.
  - reset mid-DRAIN or mid-STEP aborts immediately to IDLE.
- clk_en = 1 in FLUSH, RUN, STEP, DRAIN; 0 in IDLE and HALTED.
- flush = 1 only in FLUSH (exactly one cycle).
- stall (combinational) = clk_en & id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt). Register 0 never stalls.
- Transitions. Priority is top to bottom within each state.
  - IDLE:
    - start -> RUN.
    - else step_req -> STEP.
    - else stay.
  - FLUSH: unconditionally -> RUN.
  - RUN:
    - id_halt & !stall -> DRAIN, drain counter loaded with DRAIN_CYCLES.
    - else stop_req -> IDLE.
    - else stay.
    - id_halt beats a simultaneous stop_req.
  - STEP:
    - id_halt & !stall -> DRAIN.
    - else -> IDLE.
    - STEP always lasts exactly one cycle, even when stalled.
  - DRAIN:
    - counter decrements each cycle; when counter == 1 -> HALTED.
    - DRAIN lasts exactly DRAIN_CYCLES cycles.
    - start, step_req and stop_req are ignored.
    - stall is still evaluated; a second id_halt is ignored.
  - HALTED:
    - start -> FLUSH; cycle_count cleared to 0 on that edge.
    - step_req and stop_req are ignored.
- id_halt is recognised only while stall = 0, so a HALT held in IF/ID by a load-use stall is accepted on the first non-stalled cycle.
- cycle_count:
  - +1 on every edge where clk_en = 1 (FLUSH counts).
  - saturates at 2^CNT_W-1 with no wrap.
  - clear-on-start from HALTED takes precedence over increment.
- Latency:
  - debug request sampled on edge N; clk_en changes in cycle N+1.
  - HALT latched in ID at edge N; halted=1 from cycle N+1+DRAIN_CYCLES.
- Simultaneous start and step_req in IDLE: start wins.

Test Plan:
- Reset:
  - stimulus: reset=1 for 2 cycles with start=1.
  - required: state IDLE, clk_en=0, halted=0, cycle_count=0; no RUN until after reset is released.
- Step:
  - stimulus: in IDLE pulse step_req 3 times, separated by idle gaps.
  - required: clk_en high for exactly 3 single cycles; cycle_count=3; busy mirrors clk_en.
- Load-use:
  - stimulus: RUN with id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5.
  - required: stall=1.
  - stimulus: same with id_ex_rt=0.
  - required: stall=0.
  - stimulus: in IDLE with the same hazard inputs.
  - required: stall=0.
- Halt drain:
  - stimulus: RUN, id_halt=1 at edge N, with stop_req=1 on the same cycle.
  - required: DRAIN entered (not IDLE); clk_en=1 for 4 cycles; halted=1 and clk_en=0 from cycle N+5; later step_req has no effect.
- Halt under stall:
  - stimulus: id_halt=1 together with an active load-use hazard for 1 cycle, then hazard clears.
  - required: DRAIN entered one cycle later than in the non-stalled case.
- Restart:
  - stimulus: from HALTED assert start.
  - required: one FLUSH cycle (flush=1, clk_en=1, cycle_count reads 0 then 1), then RUN.
  - stimulus: assert reset in the 2nd DRAIN cycle.
  - required: IDLE next cycle, all outputs 0.
